record_store: RTL

RECORD_STORE -- requirements
Module: record_store

---
 rtl/record_store.sv | 295 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/record_store.sv
// -----------------------------------------------------------------------------
// record_store
//
// Slot-addressed record store with a valid bitmap, occupancy count and an
// optional "best score" tracker.
//
// Parameters
//   DEPTH   : number of record slots (power of two, 2..256)
//   DATA_W  : record width in bits
//   SCORE_W : score field width; the score is req_data[SCORE_W-1:0], unsigned
//
// Ports
//   clk, sys_rst          : clock (rising edge), asynchronous active-high reset
//   req_valid / req_ready : request handshake
//   req_op                : 00 read, 01 write, 10 append, 11 delete
//   req_idx, req_data     : target slot and write payload
//   rsp_valid             : one-cycle pulse, one cycle after each accepted request
//   rsp_data, rsp_idx     : read data and slot actually used (held between pulses)
//   rsp_err               : request rejected (empty slot / store full)
//   count, full, empty    : occupancy
//   best_valid/idx/score  : slot holding the maximum valid score
//
// Optional feature (macro RECORD_STORE_BEST_EN):
//   When defined, the best_* outputs track the maximum valid score. Losing the
//   current best (delete, or overwrite with a lower score) triggers a DEPTH
//   cycle RESCAN during which req_ready is low. When undefined, best_* are 0
//   and req_ready is constant 1 outside reset.
// -----------------------------------------------------------------------------
module record_store #(
    parameter int  DEPTH   = 16,
    parameter int  DATA_W  = 160,
    parameter int  SCORE_W = 16,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               sys_rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [IDX_W-1:0]   req_idx,
    input  logic [DATA_W-1:0]  req_data,
    output logic               rsp_valid,
    output logic [DATA_W-1:0]  rsp_data,
    output logic [IDX_W-1:0]   rsp_idx,
    output logic               rsp_err,
    output logic [IDX_W:0]     count,
    output logic               full,
    output logic               empty,
    output logic               best_valid,
    output logic [IDX_W-1:0]   best_idx,
    output logic [SCORE_W-1:0] best_score
);

    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_APPEND = 2'b10;
    localparam logic [1:0] OP_DELETE = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        RESCAN = 1'b1
    } state_t;

    state_t              state_reg;
    state_t              state_next;

    // Record payload storage: never reset, so it maps onto block RAM.
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [DEPTH-1:0]    valid_reg;
    logic [IDX_W:0]      count_reg;
    logic                rsp_valid_reg;
    logic [DATA_W-1:0]   rsp_data_reg;
    logic [IDX_W-1:0]    rsp_idx_reg;
    logic                rsp_err_reg;

    logic                accept;
    logic                slot_valid;
    logic                free_found;
    logic [DEPTH-1:0]    free_vec;
    logic [DEPTH-1:0]    free_onehot;
    logic [IDX_W-1:0]    free_idx;
    logic                wr_en;
    logic [IDX_W-1:0]    wr_idx;
    logic                del_en;
    logic                op_err;
    logic                rescan_start;
    logic                scan_last;

    assign accept     = req_valid && req_ready;
    assign slot_valid = valid_reg[req_idx];

    // Lowest empty slot: isolate the lowest set bit of the free vector, then
    // encode the one-hot into a binary index bit by bit.
    assign free_vec    = ~valid_reg;
    assign free_onehot = free_vec & ~(free_vec - 1'b1);
    assign free_found  = |free_vec;

    for (genvar gi = 0; gi < IDX_W; gi++) begin : g_free_enc
        logic [DEPTH-1:0] sel;
        for (genvar gj = 0; gj < DEPTH; gj++) begin : g_sel
            assign sel[gj] = free_onehot[gj] && (((gj >> gi) & 1) == 1);
        end
        assign free_idx[gi] = |sel;
    end

    // Request decode. wr_idx doubles as the reported slot: it equals req_idx
    // for everything except a successful append.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = req_idx;
        del_en = 1'b0;
        op_err = 1'b0;
        if (accept) begin
            case (req_op)
                OP_READ: begin
                    op_err = !slot_valid;
                end
                OP_WRITE: begin
                    wr_en = 1'b1;
                end
                OP_APPEND: begin
                    if (free_found) begin
                        wr_en  = 1'b1;
                        wr_idx = free_idx;
                    end else begin
                        op_err = 1'b1;
                    end
                end
                default: begin
                    del_en = slot_valid;
                    op_err = !slot_valid;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= req_data;
        end
    end

    // A write lands in mem on its accept edge, so a read accepted on the
    // following edge already sees the new contents.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            valid_reg     <= '0;
            count_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_idx_reg   <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            rsp_valid_reg <= accept;
            if (accept) begin
                rsp_err_reg  <= op_err;
                rsp_idx_reg  <= wr_idx;
                rsp_data_reg <= (req_op == OP_READ && slot_valid) ? mem[req_idx] : '0;
            end
            if (wr_en) begin
                valid_reg[wr_idx] <= 1'b1;
                if (!valid_reg[wr_idx]) begin
                    count_reg <= count_reg + 1'b1;
                end
            end else if (del_en) begin
                valid_reg[req_idx] <= 1'b0;
                count_reg          <= count_reg - 1'b1;
            end
        end
    end

    // FSM: state register plus next-state/ready decode.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (rescan_start) begin
                    state_next = RESCAN;
                end
            end
            RESCAN: begin
                if (scan_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef RECORD_STORE_BEST_EN
    // Shadow copy of each slot's score so the scan can look at one slot per
    // cycle without competing with the payload RAM port.
    logic [SCORE_W-1:0]  score_mem [DEPTH];
    logic [SCORE_W-1:0]  new_score;
    logic                best_valid_reg;
    logic [IDX_W-1:0]    best_idx_reg;
    logic [SCORE_W-1:0]  best_score_reg;
    logic [IDX_W-1:0]    scan_idx_reg;
    logic                cand_valid_reg;
    logic [IDX_W-1:0]    cand_idx_reg;
    logic [SCORE_W-1:0]  cand_score_reg;
    logic [SCORE_W-1:0]  cur_score;
    logic                best_take;
    logic                scan_take;

    assign new_score = req_data[SCORE_W-1:0];

    // Strictly greater replaces the best, so ties keep the incumbent.
    assign best_take = wr_en && (!best_valid_reg || new_score > best_score_reg);

    // Only losing the current best forces a full rescan; any other change
    // can be folded in incrementally.
    assign rescan_start = accept && best_valid_reg && (req_idx == best_idx_reg) &&
                          ((req_op == OP_DELETE) ||
                           (req_op == OP_WRITE && new_score < best_score_reg));

    assign cur_score = score_mem[scan_idx_reg];
    // Strict compare while walking upwards keeps the lowest index on ties.
    assign scan_take = valid_reg[scan_idx_reg] &&
                       (!cand_valid_reg || cur_score > cand_score_reg);
    assign scan_last = (scan_idx_reg == IDX_W'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            score_mem[wr_idx] <= new_score;
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            best_valid_reg <= 1'b0;
            best_idx_reg   <= '0;
            best_score_reg <= '0;
            scan_idx_reg   <= '0;
            cand_valid_reg <= 1'b0;
            cand_idx_reg   <= '0;
            cand_score_reg <= '0;
        end else if (state_reg == IDLE) begin
            scan_idx_reg   <= '0;
            cand_valid_reg <= 1'b0;
            cand_idx_reg   <= '0;
            cand_score_reg <= '0;
            if (best_take) begin
                best_valid_reg <= 1'b1;
                best_idx_reg   <= wr_idx;
                best_score_reg <= new_score;
            end
        end else begin
            scan_idx_reg <= scan_idx_reg + 1'b1;
            if (scan_take) begin
                cand_valid_reg <= 1'b1;
                cand_idx_reg   <= scan_idx_reg;
                cand_score_reg <= cur_score;
            end
            // Last slot is merged directly into the result so the scan
            // finishes in exactly DEPTH cycles.
            if (scan_last) begin
                best_valid_reg <= scan_take || cand_valid_reg;
                best_idx_reg   <= scan_take ? scan_idx_reg : cand_idx_reg;
                best_score_reg <= scan_take ? cur_score : cand_score_reg;
            end
        end
    end

    assign best_valid = best_valid_reg;
    assign best_idx   = best_idx_reg;
    assign best_score = best_score_reg;
`else
    assign rescan_start = 1'b0;
    assign scan_last    = 1'b1;
    assign best_valid   = 1'b0;
    assign best_idx     = '0;
    assign best_score   = '0;
`endif

    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_idx   = rsp_idx_reg;
    assign rsp_err   = rsp_err_reg;
    assign count     = count_reg;
    assign full      = (count_reg == (IDX_W + 1)'(DEPTH));
    assign empty     = (count_reg == '0);

endmodule
